rom_sequencer: RTL and testbench

ROM-driven microsequencer that steps through an external 16-word program memory. Each word supplies an 8-bit output pattern and two 4-bit successor addresses. The block holds each output pattern for a fixed number of clock cycles. It then selects the next address from the 1-bit condition input `x`. It sits between a combinational ROM (address out, data in) and downstream logic consuming `z7_z0`.

---
 rtl/rom_seq_pkg.sv | 36 +++
 rtl/rom_seq_hold_counter.sv | 33 +++
 rtl/rom_sequencer.sv | 69 ++++++
 tb/tb_rom_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared field layout, widths and helpers for the ROM-driven
// microsequencer. Optional feature macro used by the top level:
// ROM_SEQ_STEP_STROBE_EN (adds a one-cycle `step` strobe output).
package rom_seq_pkg;

    // Field positions inside one 16-bit program word
    localparam int NEXT0_MSB = 15;
    localparam int NEXT0_LSB = 12;
    localparam int NEXT1_MSB = 11;
    localparam int NEXT1_LSB = 8;
    localparam int PAT_MSB   = 7;
    localparam int PAT_LSB   = 0;

    localparam int ADDR_W = 4;
    localparam int PAT_W  = 8;
    localparam int WORD_W = 16;

    // Clock cycles each output pattern is held for, unless overridden
    localparam int DEFAULT_HOLD_CYCLES = 10;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PAT_W-1:0]  pat_t;
    typedef logic [WORD_W-1:0] word_t;

    // Successor address chosen by the branch condition: a plain field select,
    // no increment and no wrap handling is ever needed.
    function automatic addr_t selectNext(input word_t word, input logic condX);
        return condX ? word[NEXT1_MSB:NEXT1_LSB] : word[NEXT0_MSB:NEXT0_LSB];
    endfunction

    // Output pattern carried by a program word
    function automatic pat_t selectPattern(input word_t word);
        return word[PAT_MSB:PAT_LSB];
    endfunction

endpackage

// File: rtl/rom_seq_hold_counter.sv
// rom_seq_hold_counter: free-running modulo-HOLD_CYCLES counter with async
// active-low reset. `last` is high while the count sits on its final value,
// which marks the next rising edge as a step edge for the sequencer.
module rom_seq_hold_counter
    import rom_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset_,
    output logic last
);

    // HOLD_CYCLES is at least 2, so the width is always at least one bit
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..HOLD_CYCLES-1 and wrap; reset discards any partial count
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: steps through an external combinational 16-word program ROM.
// Every HOLD_CYCLES clocks the current word's pattern is registered onto
// z7_z0 and the address moves to one of the word's two successors, picked
// by `x`. Define ROM_SEQ_STEP_STROBE_EN to get a registered `step` strobe
// that is high in the cycle the new address/pattern appear.
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              x,
    input  logic [WORD_W-1:0] d15_d0,
    output logic [ADDR_W-1:0] a3_a0,
    output logic [PAT_W-1:0]  z7_z0
`ifdef ROM_SEQ_STEP_STROBE_EN
    ,
    output logic              step
`endif
);

    logic  w_last;
    addr_t w_nextAddr;
    pat_t  w_nextPat;
    addr_t r_addr;
    pat_t  r_pat;

    rom_seq_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_holdCounter (
        .clock  (clock),
        .reset_ (reset_),
        .last   (w_last)
    );

    assign w_nextAddr = selectNext(d15_d0, x);
    assign w_nextPat  = selectPattern(d15_d0);

    // On the step edge latch the current word's pattern and jump to its successor
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_addr <= '0;
            r_pat  <= '0;
        end else if (w_last) begin
            r_addr <= w_nextAddr;
            r_pat  <= w_nextPat;
        end
    end

    assign a3_a0 = r_addr;
    assign z7_z0 = r_pat;

`ifdef ROM_SEQ_STEP_STROBE_EN
    logic r_step;

    // Strobe lines up with the cycle in which the new address/pattern are visible
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_step <= 1'b0;
        end else begin
            r_step <= w_last;
        end
    end

    assign step = r_step;
`endif

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: directed table of program steps, hand-written corner
// sequences (x toggling between step edges, reset mid-step) and a randomized
// phase compared against an edge-counting reference model.
module tb_rom_sequencer;

    localparam int HOLD = 10;
    localparam int RANDOM_CYCLES = 600;

    logic        clock;
    logic        reset_;
    logic        x;
    logic [15:0] d15_d0;
    logic [3:0]  a3_a0;
    logic [7:0]  z7_z0;
`ifdef ROM_SEQ_STEP_STROBE_EN
    logic        step;
`endif

    logic [15:0] rom [16];

    int vecCount  = 0;
    int missCount = 0;

    rom_sequencer #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .x      (x),
        .d15_d0 (d15_d0),
        .a3_a0  (a3_a0),
        .z7_z0  (z7_z0)
`ifdef ROM_SEQ_STEP_STROBE_EN
        ,
        .step   (step)
`endif
    );

    // Combinational ROM: data for the current address is valid in the same cycle
    assign d15_d0 = rom[a3_a0];

    // Free-running clock, first rising edge at t=5
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: count rising edges since reset release; every HOLD-th
    // edge takes the word at the modelled address and moves on.
    int          mEdges;
    logic [3:0]  mAddr;
    logic [7:0]  mPat;
    logic        mStep;
    logic [15:0] mWord;
    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            mEdges = 0;
            mAddr  = 4'd0;
            mPat   = 8'd0;
            mStep  = 1'b0;
        end else begin
            mEdges = mEdges + 1;
            mStep  = 1'b0;
            if (mEdges % HOLD == 0) begin
                mWord = rom[mAddr];
                mPat  = mWord[7:0];
                mAddr = x ? mWord[11:8] : mWord[15:12];
                mStep = 1'b1;
            end
        end
    end

    // One comparison of the visible outputs against required values
    task automatic checkOutput(input string name, input logic [3:0] expAddr,
                               input logic [7:0] expPat, input logic expStep);
        logic bad;
        vecCount++;
        bad = (a3_a0 !== expAddr) || (z7_z0 !== expPat);
`ifdef ROM_SEQ_STEP_STROBE_EN
        bad = bad || (step !== expStep);
        if (bad) begin
            missCount++;
            $display("[TB] FAIL %s: got a3_a0=%h z7_z0=%h step=%b, required a3_a0=%h z7_z0=%h step=%b",
                     name, a3_a0, z7_z0, step, expAddr, expPat, expStep);
        end
`else
        if (bad) begin
            missCount++;
            $display("[TB] FAIL %s: got a3_a0=%h z7_z0=%h, required a3_a0=%h z7_z0=%h (step %b n/a)",
                     name, a3_a0, z7_z0, expAddr, expPat, expStep);
        end
`endif
    endtask

    // Run one full step from a negedge: outputs must hold for HOLD-1 edges
    // and change on the HOLD-th. With toggle set, x wanders until the edge
    // before the step edge and only then settles on xVal.
    task automatic applyStimulus(input string name, input logic xVal, input logic toggle,
                                 input logic [3:0] oldAddr, input logic [7:0] oldPat,
                                 input logic [3:0] newAddr, input logic [7:0] newPat);
        x = toggle ? ~xVal : xVal;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clock);
            if (i < HOLD)
                checkOutput({name, "_hold"}, oldAddr, oldPat, 1'b0);
            else
                checkOutput({name, "_step"}, newAddr, newPat, 1'b1);
            if (toggle && i < HOLD - 1)
                x = 1'($urandom);
            else if (toggle && i == HOLD - 1)
                x = xVal;
        end
    endtask

    typedef struct {
        string      name;
        logic       xVal;
        logic [3:0] expAddr;
        logic [7:0] expPat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [3:0] prevAddr;
        logic [7:0] prevPat;

        // Program: spec words plus a few bench-chosen words to close the chain
        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0]  = 16'h120F;
        rom[1]  = 16'h2255;
        rom[2]  = 16'h515B;
        rom[5]  = 16'h780C;
        rom[8]  = 16'h9F84;
        rom[9]  = 16'hF2A5;
        rom[13] = 16'h0077;
        rom[15] = 16'h3DE3;

        vecs[0] = '{"first_step",  1'b1, 4'd2,  8'h0F};
        vecs[1] = '{"branch_x0",   1'b0, 4'd5,  8'h5B};
        vecs[2] = '{"chain_x1",    1'b1, 4'd8,  8'h0C};
        vecs[3] = '{"chain_x0",    1'b0, 4'd9,  8'h84};
        vecs[4] = '{"addr9_x0",    1'b0, 4'd15, 8'hA5};
        vecs[5] = '{"addr15_x1",   1'b1, 4'd13, 8'hE3};
        vecs[6] = '{"addr13_x0",   1'b0, 4'd0,  8'h77};

        // Reset is visible before any clock edge
        x      = 1'b1;
        reset_ = 1'b0;
        #1;
        checkOutput("reset_state", 4'd0, 8'h00, 1'b0);

        @(negedge clock);
        reset_ = 1'b1;

        prevAddr = 4'd0;
        prevPat  = 8'h00;
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].name, vecs[v].xVal, 1'b0, prevAddr, prevPat,
                          vecs[v].expAddr, vecs[v].expPat);
            prevAddr = vecs[v].expAddr;
            prevPat  = vecs[v].expPat;
        end

        // x toggled between step edges, settling to 0 for the step edge
        applyStimulus("toggle_x0", 1'b0, 1'b1, 4'd0, 8'h77, 4'd1, 8'h0F);
        // Same again from address 1 (both successors 2): settle to 1
        applyStimulus("toggle_x1", 1'b1, 1'b1, 4'd1, 8'h0F, 4'd2, 8'h55);

        // Reset in the middle of a step discards the partial count
        x = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            checkOutput("pre_reset_hold", 4'd2, 8'h55, 1'b0);
        end
        reset_ = 1'b0;
        #1;
        checkOutput("mid_step_reset", 4'd0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("in_reset", 4'd0, 8'h00, 1'b0);
        reset_ = 1'b1;
        applyStimulus("after_reset", 1'b1, 1'b0, 4'd0, 8'h00, 4'd2, 8'h0F);

        // Randomized program and x, compared against the reference model
        reset_ = 1'b0;
        foreach (rom[i]) rom[i] = 16'($urandom);
        #1;
        checkOutput("rand_reset", mAddr, mPat, mStep);
        @(negedge clock);
        reset_ = 1'b1;
        x      = 1'($urandom);
        for (int c = 0; c < RANDOM_CYCLES; c++) begin
            @(negedge clock);
            checkOutput("random", mAddr, mPat, mStep);
            x = 1'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                reset_ = 1'b0;
                #1;
                checkOutput("random_reset", 4'd0, 8'h00, 1'b0);
                @(negedge clock);
                reset_ = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
